fifo_sync_flex: RTL and testbench

Parametrised single-clock FIFO in fabric logic, generalising the fixed 512x18/512x9 FIFO wrappers to any power-of-two depth and any data width. It adds the following:
- programmable almost-full and almost-empty thresholds,
- an exported occupancy count,
- an optional output register stage,
- sticky overflow/underflow error flags.

It sits between sample-producing interface blocks (e.g. ADC serial interfaces) and the Wishbone/DMA read side when a hard FIFO block is unavailable or the wrong shape.

---
 rtl/fifo_sync_flex.sv | 178 +++++++++++++++++
 tb/tb_fifo_sync_flex.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_flex.sv
// ============================================================================
// Module   : fifo_sync_flex
// Brief    : Single-clock fabric FIFO with threshold flags, occupancy count,
//            optional output register and optional sticky error flags
//            (enabled by FIFO_SYNC_FLEX_ERR_FLAGS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_sync_flex #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 9,
  parameter int AF_THRESH  = 4,
  parameter int AE_THRESH  = 4,
  parameter int REG_RD     = 0
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Flush,
  input  logic                  PUSH,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  POP,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Almost_Full,
  output logic                  Almost_Empty,
  output logic [3:0]            PUSH_FLAG,
  output logic [3:0]            POP_FLAG,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_HALF  = CW'(DEPTH / 2);
  localparam logic [CW-1:0] C_QUART = CW'(DEPTH / 4);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
  localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);

  // Coarse level code shared by the free-space and occupancy flags
  function automatic logic [3:0] f_level_code(input logic [CW-1:0] v);
    if (v == '0)           return 4'h0;
    else if (v == C_ONE)   return 4'h1;
    else if (v < C_QUART)  return 4'h2;
    else if (v < C_HALF)   return 4'h4;
    else if (v < C_DEPTH)  return 4'h8;
    else                   return 4'hF;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_af;
  logic                  r_ae;
  logic [3:0]            r_push_flag;
  logic [3:0]            r_pop_flag;
  logic [DATA_WIDTH-1:0] r_dout;

  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic [CW-1:0]         w_count_nxt;
  logic [CW-1:0]         w_free_nxt;

  assign w_push_ok = PUSH && !r_full  && !Flush;
  assign w_pop_ok  = POP  && !r_empty && !Flush;

  always_comb begin
    w_count_nxt = r_count;
    if (Flush)
      w_count_nxt = '0;
    else if (w_push_ok && !w_pop_ok)
      w_count_nxt = r_count + C_ONE;
    else if (w_pop_ok && !w_push_ok)
      w_count_nxt = r_count - C_ONE;
  end

  assign w_free_nxt = C_DEPTH - w_count_nxt;

  always_ff @(posedge Clk) begin
    if (w_push_ok)
      r_mem[r_wptr] <= DIN;
  end

  // Flags are decoded from the next count so they leave the register glitch-free
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_af        <= 1'b0;
      r_ae        <= 1'b1;
      r_push_flag <= 4'hF;
      r_pop_flag  <= 4'h0;
      r_dout      <= '0;
    end else begin
      if (Flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push_ok)
          r_wptr <= r_wptr + 1'b1;
        if (w_pop_ok) begin
          r_rptr <= r_rptr + 1'b1;
          r_dout <= r_mem[r_rptr];
        end
      end
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == C_DEPTH);
      r_empty     <= (w_count_nxt == '0);
      r_af        <= (w_free_nxt <= C_AF);
      r_ae        <= (w_count_nxt <= C_AE);
      r_push_flag <= f_level_code(w_free_nxt);
      r_pop_flag  <= f_level_code(w_count_nxt);
    end
  end

  generate
    if (REG_RD != 0) begin : g_reg_rd
      logic [DATA_WIDTH-1:0] r_dout_q;
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
          r_dout_q <= '0;
        else
          r_dout_q <= r_dout;
      end
      assign DOUT = r_dout_q;
    end else begin : g_no_reg_rd
      assign DOUT = r_dout;
    end
  endgenerate

`ifdef FIFO_SYNC_FLEX_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (Flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (PUSH && r_full)
        r_overflow <= 1'b1;
      if (POP && r_empty)
        r_underflow <= 1'b1;
    end
  end

  assign Overflow  = r_overflow;
  assign Underflow = r_underflow;
`else
  assign Overflow  = 1'b0;
  assign Underflow = 1'b0;
`endif

  assign Count        = r_count;
  assign Full         = r_full;
  assign Empty        = r_empty;
  assign Almost_Full  = r_af;
  assign Almost_Empty = r_ae;
  assign PUSH_FLAG    = r_push_flag;
  assign POP_FLAG     = r_pop_flag;

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync_flex.sv
// ============================================================================
// Module   : tb_fifo_sync_flex
// Brief    : Scoreboard bench for fifo_sync_flex (DEPTH=8 with output register,
//            plus a default-parameter instance for reset values).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_sync_flex;

  localparam int DW     = 8;
  localparam int AW     = 3;
  localparam int REG_RD = 1;

`ifdef FIFO_SYNC_FLEX_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic          Clk;
  logic          Rst_n;
  logic          Flush;
  logic          PUSH;
  logic [DW-1:0] DIN;
  logic          POP;
  logic [DW-1:0] DOUT;
  logic          Full, Empty, Almost_Full, Almost_Empty;
  logic [3:0]    PUSH_FLAG, POP_FLAG;
  logic [AW:0]   Count;
  logic          Overflow, Underflow;

  logic          b_flush, b_push, b_pop;
  logic [17:0]   b_din, b_dout;
  logic          b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [3:0]    b_pf, b_qf;
  logic [9:0]    b_count;

  int checks   = 0;
  int failures = 0;

  fifo_sync_flex #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(2), .AE_THRESH(1), .REG_RD(REG_RD)
  ) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush), .PUSH(PUSH), .DIN(DIN), .POP(POP),
    .DOUT(DOUT), .Full(Full), .Empty(Empty), .Almost_Full(Almost_Full),
    .Almost_Empty(Almost_Empty), .PUSH_FLAG(PUSH_FLAG), .POP_FLAG(POP_FLAG),
    .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
  );

  fifo_sync_flex u_big (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(b_flush), .PUSH(b_push), .DIN(b_din), .POP(b_pop),
    .DOUT(b_dout), .Full(b_full), .Empty(b_empty), .Almost_Full(b_af),
    .Almost_Empty(b_ae), .PUSH_FLAG(b_pf), .POP_FLAG(b_qf),
    .Count(b_count), .Overflow(b_ovf), .Underflow(b_unf)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: queue of written data plus a list of reads due on a given edge
  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } pend_t;

  logic [DW-1:0] data_q[$];
  pend_t         chk_q[$];
  int            m_cnt = 0;
  int            cyc   = 0;

  always @(posedge Clk) begin
    logic push_ok, pop_ok;
    pend_t p;
    cyc++;
    if (!Rst_n) begin
      data_q.delete();
      chk_q.delete();
      m_cnt = 0;
    end else if (Flush) begin
      data_q.delete();
      m_cnt = 0;
    end else begin
      push_ok = PUSH && (m_cnt < (1 << AW));
      pop_ok  = POP && (m_cnt > 0);
      if (pop_ok) begin
        p.due = cyc + REG_RD;
        p.d   = data_q.pop_front();
        chk_q.push_back(p);
        m_cnt--;
      end
      if (push_ok) begin
        data_q.push_back(DIN);
        m_cnt++;
      end
    end
    #1;
    while (chk_q.size() > 0 && chk_q[0].due == cyc) begin
      p = chk_q.pop_front();
      chk("dout", 64'(DOUT), 64'(p.d));
    end
  end

  task automatic step(input logic p, input logic q, input logic [DW-1:0] d, input logic f);
    PUSH  = p;
    POP   = q;
    DIN   = d;
    Flush = f;
    @(negedge Clk);
  endtask

  logic [3:0] fill_pf [8] = '{4'h8, 4'h8, 4'h8, 4'h8, 4'h4, 4'h4, 4'h1, 4'h0};
  logic [3:0] fill_qf [8] = '{4'h1, 4'h4, 4'h4, 4'h8, 4'h8, 4'h8, 4'h8, 4'hF};
  logic       fill_af [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       fill_ae [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst_n = 1'b0; Flush = 1'b0; PUSH = 1'b0; POP = 1'b0; DIN = '0;
    b_flush = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_din = '0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    chk("big_empty", 64'(b_empty), 64'd1);
    chk("big_ae", 64'(b_ae), 64'd1);
    chk("big_full", 64'(b_full), 64'd0);
    chk("big_af", 64'(b_af), 64'd0);
    chk("big_push_flag", 64'(b_pf), 64'hF);
    chk("big_pop_flag", 64'(b_qf), 64'h0);
    chk("big_count", 64'(b_count), 64'd0);
    chk("big_dout", 64'(b_dout), 64'd0);
    chk("rst_push_flag", 64'(PUSH_FLAG), 64'hF);
    chk("rst_dout", 64'(DOUT), 64'd0);

    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, DW'(i), 1'b0);
      chk("fill_count", 64'(Count), 64'(i));
      chk("fill_push_flag", 64'(PUSH_FLAG), 64'(fill_pf[i-1]));
      chk("fill_pop_flag", 64'(POP_FLAG), 64'(fill_qf[i-1]));
      chk("fill_af", 64'(Almost_Full), 64'(fill_af[i-1]));
      chk("fill_ae", 64'(Almost_Empty), 64'(fill_ae[i-1]));
      chk("fill_full", 64'(Full), 64'(i == 8));
    end

    step(1'b1, 1'b0, 8'h99, 1'b0);
    chk("ovf_count", 64'(Count), 64'd8);
    chk("ovf_full", 64'(Full), 64'd1);
    chk("ovf_flag", 64'(Overflow), 64'(ERR_EN));
    chk("ovf_unf", 64'(Underflow), 64'd0);

    repeat (3) step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("drain3_count", 64'(Count), 64'd5);
    step(1'b1, 1'b0, 8'h09, 1'b0);
    step(1'b1, 1'b0, 8'h0A, 1'b0);
    step(1'b1, 1'b0, 8'h0B, 1'b0);
    chk("refill_count", 64'(Count), 64'd8);

    step(1'b1, 1'b1, 8'hEE, 1'b0);
    chk("full_pp_count", 64'(Count), 64'd7);
    chk("full_pp_full", 64'(Full), 64'd0);

    repeat (7) step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("drain_count", 64'(Count), 64'd0);
    chk("drain_empty", 64'(Empty), 64'd1);
    chk("drain_push_flag", 64'(PUSH_FLAG), 64'hF);
    repeat (2) step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("hold_dout", 64'(DOUT), 64'h0B);

    step(1'b1, 1'b1, 8'h21, 1'b0);
    chk("empty_pp_count", 64'(Count), 64'd1);
    chk("empty_pp_unf", 64'(Underflow), 64'(ERR_EN));

    step(1'b1, 1'b0, 8'h22, 1'b0);
    step(1'b1, 1'b0, 8'h23, 1'b0);
    step(1'b1, 1'b0, 8'h24, 1'b0);
    chk("mid_count", 64'(Count), 64'd4);
    step(1'b1, 1'b1, 8'h25, 1'b0);
    chk("mid_pp_count", 64'(Count), 64'd4);
    step(1'b1, 1'b0, 8'h26, 1'b0);
    chk("pre_flush_count", 64'(Count), 64'd5);
    repeat (2) step(1'b0, 1'b0, 8'h00, 1'b0);

    step(1'b1, 1'b1, 8'h77, 1'b1);
    chk("flush_count", 64'(Count), 64'd0);
    chk("flush_empty", 64'(Empty), 64'd1);
    chk("flush_ovf", 64'(Overflow), 64'd0);
    chk("flush_unf", 64'(Underflow), 64'd0);
    chk("flush_dout", 64'(DOUT), 64'h21);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("flush_dout_hold", 64'(DOUT), 64'h21);

    step(1'b1, 1'b0, 8'h31, 1'b0);
    step(1'b1, 1'b0, 8'h32, 1'b0);
    DIN = 8'h33;
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(Count), 64'd0);
    chk("arst_empty", 64'(Empty), 64'd1);
    chk("arst_ae", 64'(Almost_Empty), 64'd1);
    chk("arst_push_flag", 64'(PUSH_FLAG), 64'hF);
    chk("arst_pop_flag", 64'(POP_FLAG), 64'h0);
    chk("arst_dout", 64'(DOUT), 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h41, 1'b0);
    chk("post_rst_count", 64'(Count), 64'd1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("pending_reads", 64'(chk_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
